fwd_hazard_unit: RTL

- Parametrised successor to the single-issue forwarding logic: owns its own EX/MEM/WB destination-tag pipeline instead of taking per-stage fields from the datapath.
- Generates per-operand ALU forward selects, store-data forwarding (load→store), and load-use stall/bubble control for NUM_SRC source operands.
- Sits beside the ID/EXE/MEM/WB pipeline registers; driven by decode-stage control, consumed by EX operand muxes, MEM store-data mux and the ID/IF stall logic.

---
 rtl/fwd_hazard_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for a single-issue EX/MEM/WB pipeline.
// Keeps its own destination-tag pipeline and produces three things: the ALU
// operand forward selects in EX, load-to-store data forwarding in MEM, and the
// load-use stall. It also keeps a saturating count of stall cycles.
module fwd_hazard_unit #(
  parameter int REG_W     = 3,
  parameter int NUM_SRC   = 2,
  parameter int STORE_SRC = 1,
  parameter int ZERO_REG  = 1,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic                     id_regwr,
  input  logic                     id_memrd,
  input  logic                     id_memwr,
  input  logic [REG_W-1:0]         id_rd,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic                     flush,
  input  logic                     stall_cnt_clr,
  output logic                     stall,
  output logic [2*NUM_SRC-1:0]     ex_fwd,
  output logic                     mem_fwd,
  output logic [CNT_W-1:0]         stall_cnt
);

  // EX keeps every source tag so operand forwarding can be resolved there.
  typedef struct packed {
    logic                     valid;
    logic                     regwr;
    logic                     memrd;
    logic                     memwr;
    logic [REG_W-1:0]         rd;
    logic [NUM_SRC*REG_W-1:0] src;
  } ex_tag_t;

  // MEM and WB only need the store-data source tag.
  typedef struct packed {
    logic             valid;
    logic             regwr;
    logic             memrd;
    logic             memwr;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] sd;
  } late_tag_t;

  ex_tag_t   ex_q;
  late_tag_t mem_q;
  late_tag_t wb_q;
  logic      src_hit;

  // Register equality. A hardwired zero register never counts as a match.
  function automatic logic match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a == b) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Load-use detection: a load in EX that writes a register the ID instruction reads.
  // The store-data operand of a store is exempt because mem_fwd covers it later.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!((i == STORE_SRC) && id_memwr) && match(ex_q.rd, id_src[i*REG_W +: REG_W]))
        src_hit = 1'b1;
    end
    stall = id_valid & !flush & ex_q.valid & ex_q.memrd & ex_q.regwr & src_hit;
  end

  // ALU operand forward selects. MEM wins over WB. A load in MEM has no result yet.
  always_comb begin
    ex_fwd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mem_q.valid && mem_q.regwr && !mem_q.memrd &&
          match(mem_q.rd, ex_q.src[i*REG_W +: REG_W]))
        ex_fwd[2*i +: 2] = 2'b10;
      else if (wb_q.valid && wb_q.regwr && match(wb_q.rd, ex_q.src[i*REG_W +: REG_W]))
        ex_fwd[2*i +: 2] = 2'b01;
    end
  end

  // A store in MEM takes its data from a load in WB that wrote the same register.
  assign mem_fwd = mem_q.valid & mem_q.memwr & wb_q.valid & wb_q.memrd & wb_q.regwr &
                   match(wb_q.rd, mem_q.sd);

  // Tag pipeline. A stalled or flushed ID instruction becomes a bubble in EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the tags are a few flops, so all of them are reset and no X ever reaches a comparator.
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value of the stage before it.
      wb_q  <= mem_q;
      mem_q <= '{valid: ex_q.valid,
                 regwr: ex_q.regwr,
                 memrd: ex_q.memrd,
                 memwr: ex_q.memwr,
                 rd:    ex_q.rd,
                 sd:    ex_q.src[STORE_SRC*REG_W +: REG_W]};
      if (id_valid && !stall && !flush)
        ex_q <= '{valid: 1'b1,
                  regwr: id_regwr,
                  memrd: id_memrd,
                  memwr: id_memwr,
                  rd:    id_rd,
                  src:   id_src};
      else
        ex_q <= '0;
    end
  end

  // Saturating stall-cycle counter. A clear takes priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall_cnt_clr)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
